btb_predictor: RTL and testbench

- Fetch-side branch predictor. Supplies Pre_Branch/Pre_PC to the NPC logic in IF0 in the same cycle as the current fetch PC (PC_out).
- Resolved-branch information from EX is written back into it.
- Structure: direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating counters, plus branch/mispredict performance counters.
- Sits beside the PC register: predicted-path producer and EX-update consumer of the IF0 next-PC interface.

---
 rtl/btb_predictor_pkg.sv | 17 +
 rtl/btb_predictor_sat_counter2.sv | 23 ++
 rtl/btb_predictor.sv | 115 +++++++++++
 tb/tb_btb_predictor.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/btb_predictor_pkg.sv
// Shared definitions for the fetch-side branch predictor.
//   WORD      : machine word / PC width.
//   BTB_DEPTH : default number of BTB entries.
//   ctr_e     : 2-bit saturating direction counter encodings.
package btb_predictor_pkg;

    localparam int unsigned WORD      = 32;
    localparam int unsigned BTB_DEPTH = 64;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

endpackage

// File: rtl/btb_predictor_sat_counter2.sv
// 2-bit saturating counter next-state function (combinational).
// Ports:
//   i_ctr   : current counter value.
//   i_taken : resolved direction; 1 counts up, 0 counts down.
//   o_ctr   : next counter value, saturating at SNT and ST.
module btb_predictor_sat_counter2
    import btb_predictor_pkg::*;
(
    input  logic [1:0] i_ctr,
    input  logic       i_taken,
    output logic [1:0] o_ctr
);

    always_comb begin
        o_ctr = i_ctr;
        if (i_taken) begin
            if (i_ctr != ST) o_ctr = i_ctr + 2'd1;
        end else begin
            if (i_ctr != SNT) o_ctr = i_ctr - 2'd1;
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with per-entry 2-bit direction counters
// and resolved-branch / mispredict performance counters.
// Ports:
//   clk, rst        : clock (rising edge) and asynchronous active-low reset.
//   PC              : current fetch PC; looked up combinationally.
//   Pre_Branch      : predicted taken for PC.
//   Pre_PC          : predicted next PC (target if taken, else PC+4).
//   Upd_Valid       : EX presents a resolved control transfer this cycle.
//   Upd_PC          : PC of the resolved instruction.
//   Upd_Taken       : actual direction.
//   Upd_Target      : actual taken target.
//   Upd_Mispredict  : EX detected a misprediction.
//   Flush           : synchronous invalidate of all entries.
//   Branch_Cnt      : number of resolved branches (registered).
//   Mispredict_Cnt  : number of mispredictions (registered).
module btb_predictor
    import btb_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES = BTB_DEPTH,
    parameter int unsigned INDEX_W = $clog2(ENTRIES),
    parameter int unsigned TAG_W   = WORD - INDEX_W - 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [WORD-1:0] PC,
    output logic            Pre_Branch,
    output logic [WORD-1:0] Pre_PC,
    input  logic            Upd_Valid,
    input  logic [WORD-1:0] Upd_PC,
    input  logic            Upd_Taken,
    input  logic [WORD-1:0] Upd_Target,
    input  logic            Upd_Mispredict,
    input  logic            Flush,
    output logic [31:0]     Branch_Cnt,
    output logic [31:0]     Mispredict_Cnt
);

    // Flat register arrays so the lookup path is purely combinational.
    logic            r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag   [ENTRIES];
    logic [WORD-1:0] r_target [ENTRIES];
    logic [1:0]      r_ctr    [ENTRIES];
    logic [31:0]     r_branch_cnt;
    logic [31:0]     r_mispredict_cnt;

    logic [INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit;
    logic [INDEX_W-1:0] w_uidx;
    logic [TAG_W-1:0]   w_utag;
    logic               w_uhit;
    logic [1:0]         w_ctr_next;
    logic               w_unused;

    // Word-aligned fetch: the low two PC bits carry no information.
    assign w_unused = ^{PC[1:0], Upd_PC[1:0]};

    // Lookup
    assign w_idx      = PC[INDEX_W+1:2];
    assign w_tag      = PC[WORD-1:INDEX_W+2];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign Pre_Branch = w_hit && r_ctr[w_idx][1];
    assign Pre_PC     = Pre_Branch ? r_target[w_idx] : PC + WORD'(4);

    // Update
    assign w_uidx = Upd_PC[INDEX_W+1:2];
    assign w_utag = Upd_PC[WORD-1:INDEX_W+2];
    assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);

    btb_predictor_sat_counter2 u_sat_counter2 (
        .i_ctr   (r_ctr[w_uidx]),
        .i_taken (Upd_Taken),
        .o_ctr   (w_ctr_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= WNT;
            end
        end else if (Flush) begin
            // Flush takes priority over a same-cycle update; ctr/target kept.
            for (int i = 0; i < int'(ENTRIES); i++) begin
                r_valid[i] <= 1'b0;
            end
        end else if (Upd_Valid) begin
            if (w_uhit) begin
                r_ctr[w_uidx] <= w_ctr_next;
                if (Upd_Taken) r_target[w_uidx] <= Upd_Target;
            end else if (Upd_Taken) begin
                r_valid[w_uidx]  <= 1'b1;
                r_tag[w_uidx]    <= w_utag;
                r_target[w_uidx] <= Upd_Target;
                r_ctr[w_uidx]    <= WT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else if (Upd_Valid) begin
            r_branch_cnt     <= r_branch_cnt + 32'd1;
            r_mispredict_cnt <= r_mispredict_cnt + 32'(Upd_Mispredict);
        end
    end

    assign Branch_Cnt     = r_branch_cnt;
    assign Mispredict_Cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_btb_predictor.sv
module tb_btb_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] PC;
    logic        Pre_Branch;
    logic [31:0] Pre_PC;
    logic        Upd_Valid;
    logic [31:0] Upd_PC;
    logic        Upd_Taken;
    logic [31:0] Upd_Target;
    logic        Upd_Mispredict;
    logic        Flush;
    logic [31:0] Branch_Cnt;
    logic [31:0] Mispredict_Cnt;

    btb_predictor dut (
        .clk            (clk),
        .rst            (rst),
        .PC             (PC),
        .Pre_Branch     (Pre_Branch),
        .Pre_PC         (Pre_PC),
        .Upd_Valid      (Upd_Valid),
        .Upd_PC         (Upd_PC),
        .Upd_Taken      (Upd_Taken),
        .Upd_Target     (Upd_Target),
        .Upd_Mispredict (Upd_Mispredict),
        .Flush          (Flush),
        .Branch_Cnt     (Branch_Cnt),
        .Mispredict_Cnt (Mispredict_Cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        br;
        logic [31:0] npc;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Monitor: inputs change just after a rising edge; outputs are sampled
    // on the following falling edge, before the next update commits.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            if (Pre_Branch !== e.br || Pre_PC !== e.npc ||
                Branch_Cnt !== e.bc || Mispredict_Cnt !== e.mc) begin
                n_fail++;
                $display("FAIL %s: got br=%0b pc=%08h bc=%0d mc=%0d, expected br=%0b pc=%08h bc=%0d mc=%0d",
                         e.name, Pre_Branch, Pre_PC, Branch_Cnt, Mispredict_Cnt,
                         e.br, e.npc, e.bc, e.mc);
            end
        end
    end

    task automatic vec(input string n, input logic rs, input logic [31:0] pc,
                       input logic uv, input logic [31:0] upc, input logic ut,
                       input logic [31:0] tg, input logic um, input logic fl,
                       input logic ebr, input logic [31:0] epc,
                       input int ebc, input int emc);
        exp_t e;
        @(posedge clk);
        #1;
        rst            = rs;
        PC             = pc;
        Upd_Valid      = uv;
        Upd_PC         = upc;
        Upd_Taken      = ut;
        Upd_Target     = tg;
        Upd_Mispredict = um;
        Flush          = fl;
        e.name = n;
        e.br   = ebr;
        e.npc  = epc;
        e.bc   = 32'(ebc);
        e.mc   = 32'(emc);
        exp_q.push_back(e);
    endtask

    localparam logic [31:0] A  = 32'h1C000010;
    localparam logic [31:0] AL = 32'h1C000110;
    localparam logic [31:0] C  = 32'h1C000020;

    initial begin
        rst = 1'b0; PC = 32'h1C000000; Upd_Valid = 0; Upd_PC = 0; Upd_Taken = 0;
        Upd_Target = 0; Upd_Mispredict = 0; Flush = 0;
        repeat (2) @(posedge clk);

        //      name          rst pc            uv upc  ut tgt           um fl   br pc            bc mc
        vec("reset_lookup",   1, 32'h1C000000, 0, 0,   0, 0,            0, 0,   0, 32'h1C000004, 0, 0);
        vec("alloc_miss",     1, A,            1, A,   1, 32'h1C000100, 1, 0,   0, 32'h1C000014, 0, 0);
        vec("hit_wt",         1, A,            1, A,   0, 0,            1, 0,   1, 32'h1C000100, 1, 1);
        vec("hit_wnt",        1, A,            1, A,   0, 0,            0, 0,   0, 32'h1C000014, 2, 2);
        vec("hit_snt",        1, A,            1, A,   1, 32'h1C000200, 0, 0,   0, 32'h1C000014, 3, 2);
        vec("snt_inc_wnt",    1, A,            1, A,   1, 32'h1C000200, 1, 0,   0, 32'h1C000014, 4, 2);
        vec("wnt_inc_wt",     1, A,            1, A,   1, 32'h1C000200, 0, 0,   1, 32'h1C000200, 5, 3);
        vec("wt_inc_st",      1, A,            1, A,   1, 32'h1C000200, 0, 0,   1, 32'h1C000200, 6, 3);
        vec("st_saturate",    1, A,            0, 0,   0, 0,            0, 0,   1, 32'h1C000200, 7, 3);
        vec("st_dec",         1, A,            1, A,   0, 0,            0, 0,   1, 32'h1C000200, 7, 3);
        vec("st_dec_wt",      1, A,            0, 0,   0, 0,            0, 0,   1, 32'h1C000200, 8, 3);
        vec("alias_alloc",    1, AL,           1, AL,  1, 32'h1C000300, 1, 0,   0, 32'h1C000114, 8, 3);
        vec("alias_old_miss", 1, A,            0, 0,   0, 0,            0, 0,   0, 32'h1C000014, 9, 4);
        vec("alias_new_hit",  1, AL,           0, 0,   0, 0,            0, 0,   1, 32'h1C000300, 9, 4);
        vec("miss_nt_upd",    1, AL,           1, A,   0, 0,            0, 0,   1, 32'h1C000300, 9, 4);
        vec("miss_nt_nochg",  1, AL,           0, 0,   0, 0,            0, 0,   1, 32'h1C000300, 10, 4);
        vec("rbw_same_cycle", 1, C,            1, C,   1, 32'h1C000400, 0, 0,   0, 32'h1C000024, 10, 4);
        vec("rbw_next_cycle", 1, C,            0, 0,   0, 0,            0, 0,   1, 32'h1C000400, 11, 4);
        vec("pc_wrap",        1, 32'hFFFFFFFC, 0, 0,   0, 0,            1, 0,   0, 32'h00000000, 11, 4);
        vec("mp_no_valid",    1, C,            0, 0,   0, 0,            0, 0,   1, 32'h1C000400, 11, 4);
        vec("flush_and_upd",  1, C,            1, 32'h1C000030, 1, 32'h1C000500, 1, 1,
                                                                              1, 32'h1C000400, 11, 4);
        vec("flush_miss_c",   1, C,            0, 0,   0, 0,            0, 0,   0, 32'h1C000024, 12, 5);
        vec("flush_no_alloc", 1, 32'h1C000030, 0, 0,   0, 0,            0, 0,   0, 32'h1C000034, 12, 5);
        vec("flush_miss_al",  1, AL,           0, 0,   0, 0,            0, 0,   0, 32'h1C000114, 12, 5);
        vec("realloc_c",      1, C,            1, C,   1, 32'h1C000600, 0, 0,   0, 32'h1C000024, 12, 5);
        vec("realloc_hit",    1, C,            0, 0,   0, 0,            0, 0,   1, 32'h1C000600, 13, 5);
        // Reset asserted mid-cycle; checked before any further rising edge.
        vec("async_reset",    0, C,            0, 0,   0, 0,            0, 0,   0, 32'h1C000024, 0, 0);
        vec("post_reset",     1, C,            0, 0,   0, 0,            0, 0,   0, 32'h1C000024, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d vectors left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
